// File: rtl/led_pkg.sv
// Shared types and helpers for the RGB status-LED PWM driver.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_SOLID   = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_e;

  // ceil(log2(v)), never below 1 so every counter has a bit
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One RGB LED: period-latched level select and registered PWM compare.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_pend,
  input  logic                i_phase,
  input  logic [PWM_BITS-1:0] i_ramp,
  input  logic [PWM_BITS-1:0] i_cnt,
  input  logic [PWM_BITS-1:0] i_duty,
  input  led_mode_e           i_mode,
  input  logic [2:0]          i_color,
  output logic                o_r,
  output logic                o_g,
  output logic                o_b
);

  logic [PWM_BITS-1:0] level_q, level_d, sel;
  logic [2:0]          led_q, led_d;

  always_comb begin
    sel = '0;
    case (i_mode)
      LED_OFF:     sel = '0;
      LED_SOLID:   sel = i_duty;
      LED_BLINK:   sel = i_phase ? i_duty : '0;
      LED_BREATHE: sel = (i_ramp < i_duty) ? i_ramp : i_duty;
      default:     sel = '0;
    endcase
    level_d = i_pend ? sel : level_q;
    led_d   = (i_cnt < level_q) ? i_color : 3'b000;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_q <= '0;
      led_q   <= '0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign o_r = led_q[2];
  assign o_g = led_q[1];
  assign o_b = led_q[0];

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel RGB LED driver: shared prescaler, PWM counter,
// blink phase and breathe ramp feeding per-channel compare units.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int NB_CHAN       = 1,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 50,
  parameter int BLINK_PERIODS = 64
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic [2*NB_CHAN-1:0]         i_mode,
  input  logic [3*NB_CHAN-1:0]         i_color,
  input  logic [PWM_BITS*NB_CHAN-1:0]  i_duty,
  output logic [NB_CHAN-1:0]           o_led_r,
  output logic [NB_CHAN-1:0]           o_led_g,
  output logic [NB_CHAN-1:0]           o_led_b,
  output logic                         o_period_tick
);

  localparam int PW = clog2_min1(PRESCALE);
  localparam int BW = clog2_min1(BLINK_PERIODS);
  localparam logic [PW-1:0]       PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [BW-1:0]       BL_LAST  = BW'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = MAX - 1'b1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                up_q, up_d;
  logic                pend_q, ptick_q;
  logic                tick, pend;

  always_comb begin
    tick    = (presc_q == PS_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    pend    = tick && (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    if (tick) cnt_d = pend ? '0 : cnt_q + 1'b1;
    blink_d = blink_q;
    phase_d = phase_q;
    ramp_d  = ramp_q;
    up_d    = up_q;
    if (pend) begin
      if (blink_q == BL_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
      // triangle: flip at the endpoints so they are not repeated
      if (up_q) begin
        ramp_d = ramp_q + 1'b1;
        if (ramp_d == MAX) up_d = 1'b0;
      end else begin
        ramp_d = ramp_q - 1'b1;
        if (ramp_d == '0) up_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      ramp_q  <= '0;
      up_q    <= 1'b1;
      pend_q  <= 1'b0;
      ptick_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      ramp_q  <= ramp_d;
      up_q    <= up_d;
      pend_q  <= pend;
      ptick_q <= pend_q;
    end
  end

  // two stages so the pulse lines up with the first compare of the new period
  assign o_period_tick = ptick_q;

  for (genvar c = 0; c < NB_CHAN; c++) begin : g_chan
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_pend    (pend),
      .i_phase   (phase_d),
      .i_ramp    (ramp_d),
      .i_cnt     (cnt_q),
      .i_duty    (i_duty[PWM_BITS*c +: PWM_BITS]),
      .i_mode    (led_mode_e'(i_mode[2*c +: 2])),
      .i_color   (i_color[3*c +: 3]),
      .o_r       (o_led_r[c]),
      .o_g       (o_led_g[c]),
      .o_b       (o_led_b[c])
    );
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl against a period-level model.
module tb_led_pwm_ctrl;

  localparam int NC = 2;
  localparam int PB = 4;
  localparam int MX = 15;
  localparam int PS = 2;
  localparam int BP = 2;
  localparam int PER = MX * PS;

  logic          clk;
  logic          rst_n;
  logic [2*NC-1:0]  i_mode;
  logic [3*NC-1:0]  i_color;
  logic [PB*NC-1:0] i_duty;
  logic [NC-1:0] o_led_r, o_led_g, o_led_b;
  logic          o_period_tick;

  int checks;
  int errors;

  int e;
  int cur_lvl [NC];
  int nxt_lvl [NC];
  logic [NC-1:0] er, eg, eb;
  logic et;
  int obs_r [NC][64];
  int obs_g [NC][64];
  int obs_b [NC][64];

  led_pwm_ctrl #(
    .NB_CHAN       (NC),
    .PWM_BITS      (PB),
    .PRESCALE      (PS),
    .BLINK_PERIODS (BP)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_mode        (i_mode),
    .i_color       (i_color),
    .i_duty        (i_duty),
    .o_led_r       (o_led_r),
    .o_led_g       (o_led_g),
    .o_led_b       (o_led_b),
    .o_period_tick (o_period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tri_f(input int n);
    int m;
    m = n % (2 * MX);
    return (m <= MX) ? m : 2 * MX - m;
  endfunction

  // level shown during period n (n >= 1), from inputs seen at its start
  function automatic int lvl_f(input int md, input int dt, input int n);
    int r;
    int ph;
    ph = (n / BP) % 2;
    case (md)
      0: r = 0;
      1: r = dt;
      2: r = ph ? dt : 0;
      default: r = (tri_f(n) < dt) ? tri_f(n) : dt;
    endcase
    return r;
  endfunction

  function automatic void reset_model();
    e = 0;
    for (int c = 0; c < NC; c++) begin
      cur_lvl[c] = 0;
      nxt_lvl[c] = 0;
      for (int k = 0; k < 64; k++) begin
        obs_r[c][k] = 0;
        obs_g[c][k] = 0;
        obs_b[c][k] = 0;
      end
    end
  endfunction

  task automatic set_ch(input int c, input int md, input int dt,
                        input int col);
    i_mode[2*c +: 2]   = md[1:0];
    i_duty[PB*c +: PB] = dt[PB-1:0];
    i_color[3*c +: 3]  = col[2:0];
  endtask

  // one clock: expected outputs after the edge, then observed counts
  task automatic step();
    int p;
    int per;
    logic [2:0] col;
    p = e;
    if (p > 0 && p % PER == 0)
      for (int c = 0; c < NC; c++) cur_lvl[c] = nxt_lvl[c];
    for (int c = 0; c < NC; c++) begin
      col = i_color[3*c +: 3];
      er[c] = ((p % PER) / PS < cur_lvl[c]) && col[2];
      eg[c] = ((p % PER) / PS < cur_lvl[c]) && col[1];
      eb[c] = ((p % PER) / PS < cur_lvl[c]) && col[0];
    end
    et = (p > 0) && (p % PER == 0);
    if ((e + 1) % PER == 0)
      for (int c = 0; c < NC; c++)
        nxt_lvl[c] = lvl_f(int'(i_mode[2*c +: 2]),
                           int'(i_duty[PB*c +: PB]), (e + 1) / PER);
    @(posedge clk);
    #1;
    e++;
    per = p / PER;
    if (per < 64)
      for (int c = 0; c < NC; c++) begin
        obs_r[c][per] += int'(o_led_r[c]);
        obs_g[c][per] += int'(o_led_g[c]);
        obs_b[c][per] += int'(o_led_b[c]);
      end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    int first;
    set_ch(0, 1, 15, 7);
    set_ch(1, 1, 15, 7);
    rst_n = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      checks++;
      if ({o_led_r, o_led_g, o_led_b, o_period_tick} !== 7'd0) begin
        errors++;
        $display("FAIL reset_hold act=%b exp=0",
                 {o_led_r, o_led_g, o_led_b, o_period_tick});
      end
    end
    rst_n = 1'b1;
    reset_model();
    first = -1;
    repeat (45) begin
      step();
      checks++;
      if ({o_led_r, o_led_g, o_led_b, o_period_tick} !== {er, eg, eb, et}) begin
        errors++;
        $display("FAIL reset_run e=%0d act=%b exp=%b", e,
                 {o_led_r, o_led_g, o_led_b, o_period_tick}, {er, eg, eb, et});
      end
      if (o_period_tick && first < 0) first = e;
    end
    checks++;
    if (first != 31) begin
      errors++;
      $display("FAIL first_tick act=%0d exp=31", first);
    end
    checks++;
    if (o_led_r !== 2'b11) begin
      errors++;
      $display("FAIL pre_async act=%b exp=11", o_led_r);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_led_r, o_led_g, o_led_b, o_period_tick} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset act=%b exp=0",
               {o_led_r, o_led_g, o_led_b, o_period_tick});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_solid();
    set_ch(0, 1, 5, 5);
    set_ch(1, 0, 9, 7);
    do_reset();
    repeat (4 * PER) begin
      step();
      checks++;
      if ({o_led_r, o_led_g, o_led_b, o_period_tick} !== {er, eg, eb, et}) begin
        errors++;
        $display("FAIL solid e=%0d act=%b exp=%b", e,
                 {o_led_r, o_led_g, o_led_b, o_period_tick}, {er, eg, eb, et});
      end
    end
    checks++;
    if (obs_r[0][2] != 10 || obs_g[0][2] != 0 || obs_b[0][2] != 10) begin
      errors++;
      $display("FAIL solid_count r=%0d g=%0d b=%0d exp=10,0,10",
               obs_r[0][2], obs_g[0][2], obs_b[0][2]);
    end
    checks++;
    if (obs_r[1][2] + obs_g[1][2] + obs_b[1][2] != 0) begin
      errors++;
      $display("FAIL off_count act=%0d exp=0",
               obs_r[1][2] + obs_g[1][2] + obs_b[1][2]);
    end
  endtask

  task automatic test_full_zero();
    set_ch(0, 1, 15, 7);
    set_ch(1, 1, 0, 7);
    do_reset();
    repeat (4 * PER) begin
      step();
      checks++;
      if ({o_led_r, o_led_g, o_led_b, o_period_tick} !== {er, eg, eb, et}) begin
        errors++;
        $display("FAIL fullzero e=%0d act=%b exp=%b", e,
                 {o_led_r, o_led_g, o_led_b, o_period_tick}, {er, eg, eb, et});
      end
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (obs_g[0][k] != PER || obs_g[1][k] != 0) begin
        errors++;
        $display("FAIL full_zero_count p=%0d act=%0d,%0d exp=%0d,0",
                 k, obs_g[0][k], obs_g[1][k], PER);
      end
    end
  endtask

  task automatic test_blink();
    int want [6] = '{0, 0, 30, 30, 0, 0};
    set_ch(0, 2, 15, 4);
    set_ch(1, 0, 0, 0);
    do_reset();
    repeat (6 * PER) begin
      step();
      checks++;
      if ({o_led_r, o_led_g, o_led_b, o_period_tick} !== {er, eg, eb, et}) begin
        errors++;
        $display("FAIL blink e=%0d act=%b exp=%b", e,
                 {o_led_r, o_led_g, o_led_b, o_period_tick}, {er, eg, eb, et});
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs_r[0][k] != want[k]) begin
        errors++;
        $display("FAIL blink_count p=%0d act=%0d exp=%0d",
                 k, obs_r[0][k], want[k]);
      end
    end
  endtask

  task automatic test_duty_change();
    set_ch(0, 1, 3, 7);
    set_ch(1, 0, 0, 0);
    do_reset();
    repeat (4 * PER) begin
      if (e == 2 * PER + 12) set_ch(0, 1, 9, 7);
      step();
      checks++;
      if ({o_led_r, o_led_g, o_led_b, o_period_tick} !== {er, eg, eb, et}) begin
        errors++;
        $display("FAIL dchg e=%0d act=%b exp=%b", e,
                 {o_led_r, o_led_g, o_led_b, o_period_tick}, {er, eg, eb, et});
      end
    end
    checks++;
    if (obs_b[0][2] != 6 || obs_b[0][3] != 18) begin
      errors++;
      $display("FAIL duty_change act=%0d,%0d exp=6,18",
               obs_b[0][2], obs_b[0][3]);
    end
  endtask

  task automatic test_breathe();
    int t;
    set_ch(0, 3, 15, 2);
    set_ch(1, 3, 7, 1);
    do_reset();
    repeat (33 * PER) begin
      step();
      checks++;
      if ({o_led_r, o_led_g, o_led_b, o_period_tick} !== {er, eg, eb, et}) begin
        errors++;
        $display("FAIL breathe e=%0d act=%b exp=%b", e,
                 {o_led_r, o_led_g, o_led_b, o_period_tick}, {er, eg, eb, et});
      end
    end
    for (int k = 1; k < 33; k++) begin
      t = (k % 30 <= 15) ? k % 30 : 30 - k % 30;
      checks++;
      if (obs_g[0][k] != 2 * t || obs_b[1][k] != 2 * ((t < 7) ? t : 7)) begin
        errors++;
        $display("FAIL breathe_count p=%0d act=%0d,%0d exp=%0d,%0d", k,
                 obs_g[0][k], obs_b[1][k], 2 * t, 2 * ((t < 7) ? t : 7));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (20 * PER) begin
      if ($urandom_range(0, 19) == 0)
        set_ch($urandom_range(0, NC - 1), $urandom_range(0, 3),
               $urandom_range(0, MX), $urandom_range(0, 7));
      step();
      checks++;
      if ({o_led_r, o_led_g, o_led_b, o_period_tick} !== {er, eg, eb, et}) begin
        errors++;
        $display("FAIL random e=%0d act=%b exp=%b", e,
                 {o_led_r, o_led_g, o_led_b, o_period_tick}, {er, eg, eb, et});
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    i_mode  = '0;
    i_color = '0;
    i_duty  = '0;
    reset_model();
    test_reset();
    test_solid();
    test_full_zero();
    test_blink();
    test_duty_change();
    test_breathe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
